param_fifo: RTL

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/param_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH; registered read data one clock after an accepted read.
// Writes to a full FIFO are dropped unless a read frees a slot on the same edge; sticky error flags record drops.
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_enable,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   read_enable,
    input  logic                   flush,
    output logic [WIDTH-1:0]       data_out,
    output logic                   data_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc, mem_we;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

    assign count      = count_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    always_comb begin
        rd_acc       = read_enable && !empty;
        // A simultaneous read frees the slot, so a full FIFO can still take a write.
        wr_acc       = write_enable && (!full || rd_acc);
        mem_we       = wr_acc && !flush;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        overflow_d   = overflow_q | (write_enable && !wr_acc);
        underflow_d  = underflow_q | (read_enable && empty);

        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                head_d = head_q + AW'(1);
            end
            if (rd_acc) begin
                tail_d       = tail_q + AW'(1);
                data_out_d   = mem_q[tail_q];
                data_valid_d = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[head_q] <= data_in;
        end
    end

endmodule
